// File: rtl/tdma_scheduler.sv
// Frame-based TDMA slot scheduler with optional lending of idle slots.
// Latency: grant is combinational from registered slot state and same-cycle pending.
// Backpressure: none; pending is sampled every cycle and a grant is offered whenever one is possible.
module tdma_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    parameter int WORK_CONSERVING  = 0
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0]   delta,
    input  logic [NUMBER_OF_QUEUES-1:0]                 pending,
    output logic                                        valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]         selection,
    output logic                                        frame_start,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]         slot
);

    localparam int NQ = NUMBER_OF_QUEUES;
    localparam int RS = REGISTER_SIZE;
    localparam int IW = $clog2(NUMBER_OF_QUEUES);

    typedef enum logic {IDLE, RUN} mode_t;

    mode_t           mode, mode_n;
    logic [IW-1:0]   cur, cur_n;
    logic [RS-1:0]   cnt, cnt_n;
    logic [RS-1:0]   shd   [NQ];
    logic [RS-1:0]   shd_n [NQ];
    logic            fs, fs_n;

    logic            delta_any;
    logic [IW-1:0]   delta_low;
    logic            nxt_found;
    logic [IW-1:0]   nxt_idx;
    logic            slot_end;
    logic            start_frame;
    logic            lend_found;
    logic [IW-1:0]   cand;

    // Lowest nonzero incoming length, and next nonzero shadow length above cur.
    always_comb begin
        delta_any = 1'b0;
        delta_low = '0;
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NQ - 1; i >= 0; i--) begin
            if (delta[i*RS +: RS] != '0) begin
                delta_any = 1'b1;
                delta_low = IW'(i);
            end
            if ((i > int'(cur)) && (shd[i] != '0)) begin
                nxt_found = 1'b1;
                nxt_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        mode_n      = mode;
        cur_n       = cur;
        cnt_n       = cnt;
        shd_n       = shd;
        fs_n        = 1'b0;
        start_frame = 1'b0;
        slot_end    = (cnt == shd[cur] - RS'(1));
        if (mode == IDLE) begin
            start_frame = 1'b1;
        end else if (slot_end) begin
            if (nxt_found) begin
                cur_n = nxt_idx;
                cnt_n = '0;
            end else begin
                start_frame = 1'b1;
            end
        end else begin
            cnt_n = cnt + RS'(1);
        end
        if (start_frame) begin
            for (int i = 0; i < NQ; i++) begin
                shd_n[i] = delta[i*RS +: RS];
            end
            cnt_n = '0;
            if (delta_any) begin
                mode_n = RUN;
                cur_n  = delta_low;
                fs_n   = 1'b1;
            end else begin
                mode_n = IDLE;
                cur_n  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode <= IDLE;
            cur  <= '0;
            cnt  <= '0;
            fs   <= 1'b0;
            for (int i = 0; i < NQ; i++) begin
                shd[i] <= '0;
            end
        end else begin
            mode <= mode_n;
            cur  <= cur_n;
            cnt  <= cnt_n;
            fs   <= fs_n;
            shd  <= shd_n;
        end
    end

    // Lending only redirects the grant; slot ownership and timing stay with cur.
    always_comb begin
        selection  = cur;
        valid      = 1'b0;
        lend_found = 1'b0;
        cand       = '0;
        if (mode == RUN) begin
            if (WORK_CONSERVING != 0) begin
                valid = |pending;
                if (!pending[cur]) begin
                    for (int k = 1; k < NQ; k++) begin
                        cand = IW'((int'(cur) + k) % NQ);
                        if (!lend_found && pending[cand]) begin
                            selection  = cand;
                            lend_found = 1'b1;
                        end
                    end
                end
            end else begin
                valid = pending[cur];
            end
        end
    end

    assign frame_start = fs;
    assign slot        = (mode == RUN) ? cur : '0;

endmodule

// File: tb/tb_tdma_scheduler.sv
module tb_tdma_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] delta;
    logic [7:0]   delta_n;
    logic [3:0]   pending;

    logic       valid_s, fs_s, valid_w, fs_w, valid_n, fs_n;
    logic [1:0] sel_s, slot_s, sel_w, slot_w, sel_n, slot_n;

    typedef struct {
        int         kind;
        logic       valid;
        logic [1:0] sel;
        logic [1:0] slot;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;

    logic [1:0] s28 [10] = '{0, 0, 1, 1, 1, 2, 3, 3, 3, 3};
    logic [1:0] s29 [3]  = '{0, 0, 3};
    logic [1:0] s30 [8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic [1:0] n6  [6]  = '{0, 0, 0, 3, 3, 3};

    always #5 clock = ~clock;

    tdma_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .WORK_CONSERVING(0)) dut_s (
        .clock(clock), .reset(reset), .delta(delta), .pending(pending),
        .valid(valid_s), .selection(sel_s), .frame_start(fs_s), .slot(slot_s));

    tdma_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .WORK_CONSERVING(1)) dut_w (
        .clock(clock), .reset(reset), .delta(delta), .pending(pending),
        .valid(valid_w), .selection(sel_w), .frame_start(fs_w), .slot(slot_w));

    tdma_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(2), .WORK_CONSERVING(0)) dut_n (
        .clock(clock), .reset(reset), .delta(delta_n), .pending(pending),
        .valid(valid_n), .selection(sel_n), .frame_start(fs_n), .slot(slot_n));

    function automatic logic [127:0] pack(input int d0, input int d1, input int d2, input int d3);
        return {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
    endfunction

    function automatic void push(input int k, input logic v, input logic [1:0] s,
                                 input logic [1:0] sl, input logic f);
        exp_t e;
        e.kind  = k;
        e.valid = v;
        e.sel   = s;
        e.slot  = sl;
        e.fs    = f;
        q.push_back(e);
    endfunction

    // One cycle: strict and lending instances share slot and frame_start expectations.
    task automatic cyc(input logic [3:0] pend, input logic [1:0] es, input logic efs,
                       input logic sv, input logic wv, input logic [1:0] ws);
        @(posedge clock);
        #1;
        pending = pend;
        push(0, sv, es, es, efs);
        push(1, wv, ws, es, efs);
    endtask

    task automatic cyc_all(input logic [1:0] es, input logic efs);
        cyc(4'hF, es, efs, 1'b1, 1'b1, es);
    endtask

    task automatic cyc_idle();
        cyc(4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [5:0] act, req;
            string nm;
            e = q.pop_front();
            case (e.kind)
                0:       begin act = {valid_s, sel_s, slot_s, fs_s}; nm = "strict"; end
                1:       begin act = {valid_w, sel_w, slot_w, fs_w}; nm = "lend";   end
                default: begin act = {valid_n, sel_n, slot_n, fs_n}; nm = "narrow"; end
            endcase
            req = {e.valid, e.sel, e.slot, e.fs};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s check %0d at %0t: {valid,sel,slot,fs} got %b_%b_%b_%b want %b_%b_%b_%b",
                         nm, checks, $time, act[5], act[4:3], act[2:1], act[0],
                         req[5], req[4:3], req[2:1], req[0]);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete, errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        reset   = 1'b0;
        delta   = '0;
        delta_n = 8'b11_00_00_11;
        pending = 4'hF;

        cyc_idle();
        checks++;
        if ({valid_s, sel_s, slot_s, fs_s, valid_w, sel_w, slot_w, fs_w,
             valid_n, sel_n, slot_n, fs_n} !== 18'd0) begin
            errors++;
            $display("FAIL reset state at %0t: strict %b_%b_%b_%b lend %b_%b_%b_%b narrow %b_%b_%b_%b",
                     $time, valid_s, sel_s, slot_s, fs_s, valid_w, sel_w, slot_w, fs_w,
                     valid_n, sel_n, slot_n, fs_n);
        end
        cyc_idle();

        // All lengths zero: stays idle, then a single 3-cycle slot owned by queue 1.
        reset = 1'b1;
        for (int p = 0; p < 3; p++) cyc_idle();
        delta = pack(0, 3, 0, 0);
        for (int p = 0; p < 6; p++) cyc_all(2'd1, (p % 3) == 0);

        // Reset with lengths {2,3,1,4}; first released edge starts a frame.
        reset = 1'b0;
        delta = pack(2, 3, 1, 4);
        cyc_idle();
        cyc_idle();
        reset = 1'b1;
        for (int p = 0; p < 20; p++) begin
            cyc_all(s28[p % 10], (p % 10) == 0);
            push(2, 1'b1, n6[p % 6], n6[p % 6], (p % 6) == 0);
        end

        // Reset hits in slot 3, count 1; the frame restarts from scratch.
        for (int p = 0; p < 8; p++) cyc_all(s28[p], p == 0);
        reset = 1'b0;
        cyc_idle();
        cyc_idle();
        reset = 1'b1;
        for (int p = 0; p < 10; p++) begin
            if (p == 3) delta = pack(2, 0, 0, 1);
            cyc_all(s28[p], p == 0);
        end

        // Zero-length slots 1 and 2 vanish from the frame.
        for (int p = 0; p < 12; p++) begin
            if (p == 10) delta = pack(2, 2, 2, 2);
            cyc_all(s29[p % 3], (p % 3) == 0);
        end

        // Equal slots with sparse requests: strict grants vs lending.
        for (int p = 0; p < 8; p++)
            cyc(4'b0100, s30[p], p == 0, s30[p] == 2'd2, 1'b1, 2'd2);
        for (int p = 0; p < 8; p++)
            cyc(4'b0001, s30[p], p == 0, s30[p] == 2'd0, 1'b1, 2'd0);
        for (int p = 0; p < 8; p++)
            cyc(4'b1001, s30[p], p == 0, (s30[p] == 2'd0) || (s30[p] == 2'd3), 1'b1,
                (s30[p] == 2'd0) ? 2'd0 : 2'd3);
        for (int p = 0; p < 3; p++)
            cyc(4'b0000, s30[p], p == 0, 1'b0, 1'b0, s30[p]);

        // Mid-frame length change only takes effect at the next frame.
        delta = pack(1, 1, 1, 1);
        for (int p = 3; p < 8; p++) cyc_all(s30[p], 1'b0);
        for (int p = 0; p < 8; p++) begin
            if (p == 5) delta = '0;
            cyc_all(2'(p % 4), (p % 4) == 0);
        end
        for (int p = 0; p < 3; p++) cyc_idle();

        @(negedge clock);
        @(negedge clock);
        done = 1'b1;
        if ((q.size() != 0) || (checks < 12)) begin
            errors++;
            $display("FAIL incomplete: %0d expectations left unchecked, %0d checks run", q.size(), checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
